posit_mul_issuer: RTL and testbench
===================================

POSIT_MUL_ISSUER -- requirements
Module: posit_mul_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before abort (1..65535).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_a input 32, in_b input 32: upstream operand pair, valid/ready.
REQ-006 SHALL have ports mul_start output 1, mul_a output 32, mul_b output 32: request to posit multiplier.
REQ-007 SHALL have ports mul_done input 1, mul_result input 32, mul_nar input 1, mul_zero input 1: multiplier response.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_result output 32, out_nar output 1, out_zero output 1, out_timeout output 1: result stream, valid/ready.
REQ-009 SHALL have port op_count output 16: completed results delivered downstream, wraps 0xFFFF->0.

Function
REQ-010 SHALL accept a pair when in_valid & in_ready; in_ready = FIFO not full; pairs leave in arrival order.
REQ-011 SHALL hold FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-012 IDLE: if FIFO non-empty, pop head into operand registers, go ISSUE next cycle.
REQ-013 Bypass: popped pair with either operand 0x80000000 -> go HOLD directly with result 0x80000000, nar=1, zero=0; no mul_start.
REQ-014 Bypass: else popped pair with either operand 0x00000000 -> go HOLD with result 0x00000000, zero=1, nar=0; no mul_start.
REQ-015 ISSUE: mul_start=1 for exactly one cycle, then WAIT; mul_a/mul_b SHALL stay stable from ISSUE until leaving WAIT.
REQ-016 WAIT: track mul_done previous-cycle value; capture mul_result/mul_nar/mul_zero on first WAIT cycle with mul_done=1 and prior sample 0 (rising edge), go HOLD.
REQ-017 mul_done already high on entering WAIT (stale level) SHALL NOT be captured; only a fresh 0->1 transition counts; prior sample reset to 1 on entering WAIT.
REQ-018 WAIT cycle counter starts at 0 on entry; at count==TIMEOUT with no edge -> go HOLD with result 0x80000000, nar=1, timeout=1.
REQ-019 Edge and timeout in same cycle: edge wins, timeout=0.
REQ-020 HOLD: out_valid=1, result fields stable; on out_valid & out_ready -> op_count+1, go IDLE (or pop next in same cycle if FIFO non-empty, per REQ-012 next cycle).
REQ-021 Push and pop in same cycle on full FIFO: pop frees entry, in_ready stays 0 that cycle (ready derived from registered full flag).
REQ-022 Push and pop on empty FIFO same cycle not possible; new pair becomes visible cycle after push.
REQ-023 Latency, empty pipeline, non-bypass: in_valid accept cycle N -> pop N+1 -> mul_start N+2 -> out_valid one cycle after captured mul_done edge.
REQ-024 Bypass latency: accept N, pop N+1, out_valid N+2.
REQ-025 Only one multiplication outstanding at any time; mul_start SHALL never assert outside ISSUE.

Reset
REQ-026 rst_n=0 at a rising edge: state IDLE, FIFO empty, in_ready=0 during reset then 1 first cycle after, mul_start=0, mul_a=mul_b=0, out_valid=0, out_result=0, out_nar=out_zero=out_timeout=0, op_count=0, counters cleared.
REQ-027 Reset mid-operation (any state) SHALL discard in-flight and queued pairs; no output generated for them.

Verification
REQ-028 Push (0x40000000,0x40000000); model mul_done rising 10 cycles after mul_start with result 0x40000000 -> one mul_start pulse, out_result 0x40000000, op_count 1.
REQ-029 Push (0x80000000,0x40000000) then (0x00000000,0x48000000) -> no mul_start; outputs 0x80000000 nar=1, then 0x00000000 zero=1, in order.
REQ-030 TIMEOUT=20, mul_done held low -> out_valid 21 cycles after WAIT entry, 0x80000000, nar=1, timeout=1.
REQ-031 mul_done held high across ISSUE, falls, rises 5 cycles later -> capture only on the later rise.
REQ-032 Push 5 pairs back-to-back with DEPTH=4, out_ready=0 -> in_ready drops at full, no loss/reorder after out_ready=1; op_count 5.
REQ-033 Assert rst_n=0 one cycle during WAIT with 3 queued -> all outputs at reset values, FIFO empty, no out_valid afterwards.

Source files
------------

// File: rtl/posit_mul_issuer_if.sv
`default_nettype none
// ============================================================================
// posit_mul_issuer_if
// ----------------------------------------------------------------------------
// Bundles the three channels around the posit multiplier issuer:
//   in_*   : upstream operand pairs (valid/ready)
//   mul_*  : request to / response from the posit multiplier
//   out_*  : result stream to downstream (valid/ready), plus op_count
// Modports:
//   slave  : the issuer itself
//   master : the environment (operand source, multiplier, result sink)
// Revision: 1.0  initial release
// ============================================================================
interface posit_mul_issuer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;

   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_done;
   logic [31:0] mul_result;
   logic        mul_nar;
   logic        mul_zero;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_nar;
   logic        out_zero;
   logic        out_timeout;
   logic [15:0] op_count;

   modport slave (
      input  in_valid, in_a, in_b,
      output in_ready,
      output mul_start, mul_a, mul_b,
      input  mul_done, mul_result, mul_nar, mul_zero,
      output out_valid, out_result, out_nar, out_zero, out_timeout, op_count,
      input  out_ready
   );

   modport master (
      output in_valid, in_a, in_b,
      input  in_ready,
      input  mul_start, mul_a, mul_b,
      output mul_done, mul_result, mul_nar, mul_zero,
      input  out_valid, out_result, out_nar, out_zero, out_timeout, op_count,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/posit_mul_issuer.sv
`default_nettype none
// ============================================================================
// posit_mul_issuer
// ----------------------------------------------------------------------------
// Queues 32-bit posit operand pairs in a small FIFO and issues them one at a
// time to an external posit multiplier. NaR and zero operands are resolved
// locally without touching the multiplier. A wait-cycle watchdog turns a
// multiplier that never answers into a NaR result flagged as timeout.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : posit_mul_issuer_if.slave (operand in, multiplier, result out)
// Parameters:
//   DEPTH   : FIFO entries, power of two, >= 2
//   TIMEOUT : WAIT cycles allowed before abort, 1..65535
// Revision: 1.0  initial release
// ============================================================================
module posit_mul_issuer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input wire                clk,
   input wire                rst_n,
   posit_mul_issuer_if.slave bus
);

   localparam int                c_aw      = $clog2(DEPTH);
   localparam logic [31:0]       c_nar     = 32'h8000_0000;
   localparam logic [31:0]       c_zero    = 32'h0000_0000;
   localparam logic [15:0]       c_timeout = 16'(TIMEOUT);
   localparam logic [c_aw-1:0]   c_ptr_one = 1;
   localparam logic [c_aw:0]     c_cnt_one = 1;
   localparam logic [c_aw:0]     c_full    = (c_aw+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // FIFO storage: {a, b}
   logic [63:0]     mem_q [DEPTH];
   logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_aw:0]   count_q, count_d;
   logic            ready_q, ready_d;

   state_t          state_q, state_d;
   logic [31:0]     opa_q, opa_d;
   logic [31:0]     opb_q, opb_d;
   logic            mul_start_q, mul_start_d;
   logic            done_prev_q, done_prev_d;
   logic [15:0]     wait_cnt_q, wait_cnt_d;
   logic            out_valid_q, out_valid_d;
   logic [31:0]     out_result_q, out_result_d;
   logic            out_nar_q, out_nar_d;
   logic            out_zero_q, out_zero_d;
   logic            out_timeout_q, out_timeout_d;
   logic [15:0]     op_count_q, op_count_d;

   logic            w_push;
   logic            w_pop;
   logic [31:0]     w_head_a;
   logic [31:0]     w_head_b;
   logic            w_done_edge;

   // Ready comes from a registered flag, so a pop on a full FIFO only
   // reopens the input one cycle later.
   assign w_push      = bus.in_valid & ready_q;
   assign w_pop       = (state_q == S_IDLE) && (count_q != '0);
   assign w_head_a    = mem_q[rd_ptr_q][63:32];
   assign w_head_b    = mem_q[rd_ptr_q][31:0];
   // done_prev_q is forced to 1 on WAIT entry so a level left high from a
   // previous transaction is not mistaken for a fresh completion.
   assign w_done_edge = bus.mul_done & ~done_prev_q;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      state_d       = state_q;
      opa_d         = opa_q;
      opb_d         = opb_q;
      mul_start_d   = 1'b0;
      done_prev_d   = done_prev_q;
      wait_cnt_d    = wait_cnt_q;
      out_valid_d   = out_valid_q;
      out_result_d  = out_result_q;
      out_nar_d     = out_nar_q;
      out_zero_d    = out_zero_q;
      out_timeout_d = out_timeout_q;
      op_count_d    = op_count_q;

      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_cnt_one;
         2'b01:   count_d = count_q - c_cnt_one;
         default: count_d = count_q;
      endcase
      ready_d = (count_d != c_full);

      case (state_q)
         S_IDLE: begin
            if (w_pop) begin
               opa_d = w_head_a;
               opb_d = w_head_b;
               // NaR dominates zero: NaR * 0 is NaR.
               if (w_head_a == c_nar || w_head_b == c_nar) begin
                  state_d       = S_HOLD;
                  out_valid_d   = 1'b1;
                  out_result_d  = c_nar;
                  out_nar_d     = 1'b1;
                  out_zero_d    = 1'b0;
                  out_timeout_d = 1'b0;
               end else if (w_head_a == c_zero || w_head_b == c_zero) begin
                  state_d       = S_HOLD;
                  out_valid_d   = 1'b1;
                  out_result_d  = c_zero;
                  out_nar_d     = 1'b0;
                  out_zero_d    = 1'b1;
                  out_timeout_d = 1'b0;
               end else begin
                  state_d     = S_ISSUE;
                  mul_start_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            state_d     = S_WAIT;
            done_prev_d = 1'b1;
            wait_cnt_d  = '0;
         end
         S_WAIT: begin
            done_prev_d = bus.mul_done;
            if (w_done_edge) begin
               state_d       = S_HOLD;
               out_valid_d   = 1'b1;
               out_result_d  = bus.mul_result;
               out_nar_d     = bus.mul_nar;
               out_zero_d    = bus.mul_zero;
               out_timeout_d = 1'b0;
            end else if (wait_cnt_q == c_timeout) begin
               state_d       = S_HOLD;
               out_valid_d   = 1'b1;
               out_result_d  = c_nar;
               out_nar_d     = 1'b1;
               out_zero_d    = 1'b0;
               out_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               op_count_d  = op_count_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         ready_q       <= 1'b0;
         state_q       <= S_IDLE;
         opa_q         <= '0;
         opb_q         <= '0;
         mul_start_q   <= 1'b0;
         done_prev_q   <= 1'b1;
         wait_cnt_q    <= '0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_nar_q     <= 1'b0;
         out_zero_q    <= 1'b0;
         out_timeout_q <= 1'b0;
         op_count_q    <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         ready_q       <= ready_d;
         state_q       <= state_d;
         opa_q         <= opa_d;
         opb_q         <= opb_d;
         mul_start_q   <= mul_start_d;
         done_prev_q   <= done_prev_d;
         wait_cnt_q    <= wait_cnt_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_nar_q     <= out_nar_d;
         out_zero_q    <= out_zero_d;
         out_timeout_q <= out_timeout_d;
         op_count_q    <= op_count_d;
      end
   end

   assign bus.in_ready    = ready_q;
   assign bus.mul_start   = mul_start_q;
   assign bus.mul_a       = opa_q;
   assign bus.mul_b       = opb_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_nar     = out_nar_q;
   assign bus.out_zero    = out_zero_q;
   assign bus.out_timeout = out_timeout_q;
   assign bus.op_count    = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_mul_issuer.sv
`default_nettype none
// ============================================================================
// tb_posit_mul_issuer
// ----------------------------------------------------------------------------
// Directed self-checking bench for posit_mul_issuer (DEPTH=4, TIMEOUT=20).
// The multiplier is modelled either manually from the stimulus sequence or by
// an automatic responder that answers 3 cycles after mul_start with a ^ b.
// Revision: 1.0  initial release
// ============================================================================
module tb_posit_mul_issuer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 20;

   logic clk = 1'b0;
   logic rst_n;

   posit_mul_issuer_if bus ();

   posit_mul_issuer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks  = 0;
   int          errors  = 0;
   int          n_start = 0;

   logic        auto_mode = 1'b0;
   logic        auto_done = 1'b0;
   logic [31:0] auto_res  = 32'h0;
   int          acnt      = 0;
   logic        man_done  = 1'b0;
   logic [31:0] man_res   = 32'h0;
   logic        man_nar   = 1'b0;
   logic        man_zero  = 1'b0;

   assign bus.mul_done   = auto_mode ? auto_done : man_done;
   assign bus.mul_result = auto_mode ? auto_res  : man_res;
   assign bus.mul_nar    = auto_mode ? 1'b0      : man_nar;
   assign bus.mul_zero   = auto_mode ? 1'b0      : man_zero;

   always @(negedge clk) begin
      if (bus.mul_start === 1'b1) n_start = n_start + 1;
   end

   // Automatic multiplier: single-cycle done pulse 3 cycles after mul_start.
   always @(negedge clk) begin
      if (!auto_mode) begin
         acnt      = 0;
         auto_done = 1'b0;
      end else begin
         if (bus.mul_start === 1'b1) begin
            acnt     = 1;
            auto_res = bus.mul_a ^ bus.mul_b;
         end else if (acnt != 0 && acnt < 15) begin
            acnt = acnt + 1;
         end
         auto_done = (acnt == 4);
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sel 0: wait for mul_start, sel 1: wait for out_valid (bounded)
   task automatic wait_for(input string tag, input int sel);
      int n;
      n = 0;
      while (!((sel == 0) ? bus.mul_start : bus.out_valid) && n < 100) begin
         tick;
         n = n + 1;
      end
      check(tag, 32'((sel == 0) ? bus.mul_start : bus.out_valid), 32'd1);
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      tick;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ta  [5];
      logic [31:0] tbb [5];
      int          start0;
      int          acc;
      int          guard;
      logic        early;
      logic        rdy;

      for (int i = 0; i < 5; i++) begin
         ta[i]  = 32'h1000_0001 + 32'(i);
         tbb[i] = 32'h0300_0010 + 32'(i * 16);
      end

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 32'h0;
      bus.in_b      = 32'h0;
      bus.out_ready = 1'b0;
      tick;
      tick;
      tick;

      // ---------------- reset state ----------------
      check("rst_in_ready",   32'(bus.in_ready),   32'd0);
      check("rst_out_valid",  32'(bus.out_valid),  32'd0);
      check("rst_mul_start",  32'(bus.mul_start),  32'd0);
      check("rst_mul_a",      bus.mul_a,           32'h0);
      check("rst_out_result", bus.out_result,      32'h0);
      check("rst_flags",      32'({bus.out_nar, bus.out_zero, bus.out_timeout}), 32'd0);
      check("rst_op_count",   32'(bus.op_count),   32'd0);
      rst_n = 1'b1;
      tick;
      check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

      // ---------------- normal multiply, exact latency ----------------
      start0 = n_start;
      push(32'h4000_0000, 32'h4000_0000);
      check("t1_pop_cycle_no_start", 32'(bus.mul_start), 32'd0);
      tick;
      check("t1_start", 32'(bus.mul_start), 32'd1);
      check("t1_mul_a", bus.mul_a, 32'h4000_0000);
      early = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (bus.out_valid || bus.mul_start || bus.mul_a != 32'h4000_0000) early = 1'b1;
      end
      check("t1_wait_quiet", 32'(early), 32'd0);
      man_res  = 32'h4000_0000;
      man_done = 1'b1;
      tick;
      man_done = 1'b0;
      check("t1_valid",   32'(bus.out_valid), 32'd1);
      check("t1_result",  bus.out_result,     32'h4000_0000);
      check("t1_flags",   32'({bus.out_nar, bus.out_zero, bus.out_timeout}), 32'd0);
      check("t1_one_start", 32'(n_start - start0), 32'd1);
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      check("t1_op_count",   32'(bus.op_count),  32'd1);
      check("t1_valid_drop", 32'(bus.out_valid), 32'd0);

      // ---------------- bypass NaR then zero ----------------
      start0 = n_start;
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h8000_0000;
      bus.in_b     = 32'h4000_0000;
      tick;
      check("t2_pop_no_valid", 32'(bus.out_valid), 32'd0);
      bus.in_a = 32'h0000_0000;
      bus.in_b = 32'h4800_0000;
      tick;
      bus.in_valid = 1'b0;
      check("t2_nar_valid",  32'(bus.out_valid), 32'd1);
      check("t2_nar_result", bus.out_result,     32'h8000_0000);
      check("t2_nar_flags",  32'({bus.out_nar, bus.out_zero, bus.out_timeout}), 32'b100);
      bus.out_ready = 1'b1;
      tick;
      wait_for("t2_zero_valid", 1);
      check("t2_zero_result", bus.out_result, 32'h0);
      check("t2_zero_flags",  32'({bus.out_nar, bus.out_zero, bus.out_timeout}), 32'b010);
      tick;
      bus.out_ready = 1'b0;
      check("t2_op_count", 32'(bus.op_count), 32'd3);
      check("t2_no_start", 32'(n_start - start0), 32'd0);

      // ---------------- timeout ----------------
      push(32'h4000_0000, 32'h3C00_0000);
      wait_for("t3_start", 0);
      early = 1'b0;
      for (int i = 0; i < 21; i++) begin
         tick;
         if (bus.out_valid) early = 1'b1;
      end
      check("t3_no_early", 32'(early), 32'd0);
      tick;
      check("t3_valid",  32'(bus.out_valid), 32'd1);
      check("t3_result", bus.out_result,     32'h8000_0000);
      check("t3_flags",  32'({bus.out_nar, bus.out_zero, bus.out_timeout}), 32'b101);
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      check("t3_op_count", 32'(bus.op_count), 32'd4);

      // ---------------- stale mul_done level ----------------
      man_done = 1'b1;
      man_res  = 32'hDEAD_BEEF;
      man_nar  = 1'b1;
      push(32'h4800_0000, 32'h4800_0000);
      wait_for("t4_start", 0);
      early = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick;
         if (bus.out_valid) early = 1'b1;
         if (i == 2) begin
            man_done = 1'b0;
            man_nar  = 1'b0;
         end
      end
      check("t4_stale_ignored", 32'(early), 32'd0);
      man_done = 1'b1;
      man_res  = 32'h1234_5678;
      tick;
      man_done = 1'b0;
      check("t4_valid",  32'(bus.out_valid), 32'd1);
      check("t4_result", bus.out_result,     32'h1234_5678);
      check("t4_flags",  32'({bus.out_nar, bus.out_zero, bus.out_timeout}), 32'd0);
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      check("t4_op_count", 32'(bus.op_count), 32'd5);

      // ---------------- backpressure, FIFO full, order ----------------
      do_reset;
      tick;
      check("t5_op_count_rst", 32'(bus.op_count), 32'd0);
      auto_mode = 1'b1;
      acc   = 0;
      guard = 0;
      while (acc < 5 && guard < 50) begin
         bus.in_valid = 1'b1;
         bus.in_a     = ta[acc];
         bus.in_b     = tbb[acc];
         rdy          = bus.in_ready;
         tick;
         if (rdy) acc = acc + 1;
         guard = guard + 1;
      end
      bus.in_valid = 1'b0;
      check("t5_accepted", 32'(acc), 32'd5);
      check("t5_full_ready", 32'(bus.in_ready), 32'd0);
      repeat (10) tick;
      check("t5_full_hold", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_for("t5_valid", 1);
         check("t5_result", bus.out_result, ta[k] ^ tbb[k]);
         tick;
      end
      bus.out_ready = 1'b0;
      check("t5_op_count", 32'(bus.op_count), 32'd5);
      auto_mode = 1'b0;
      tick;

      // ---------------- reset during WAIT with 3 queued ----------------
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = ta[i];
         bus.in_b     = tbb[i];
         tick;
      end
      bus.in_valid = 1'b0;
      check("t6_in_wait_mul_a", bus.mul_a, ta[0]);
      rst_n = 1'b0;
      tick;
      check("t6_rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("t6_rst_mul_start", 32'(bus.mul_start), 32'd0);
      check("t6_rst_mul_ab",    bus.mul_a | bus.mul_b, 32'h0);
      check("t6_rst_result",    bus.out_result,     32'h0);
      check("t6_rst_flags",     32'({bus.out_nar, bus.out_zero, bus.out_timeout}), 32'd0);
      check("t6_rst_op_count",  32'(bus.op_count),  32'd0);
      rst_n  = 1'b1;
      start0 = n_start;
      tick;
      check("t6_ready_after", 32'(bus.in_ready), 32'd1);
      early = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick;
         if (bus.out_valid || bus.mul_start) early = 1'b1;
      end
      check("t6_no_activity", 32'(early), 32'd0);
      check("t6_no_start",    32'(n_start - start0), 32'd0);
      check("t6_op_count",    32'(bus.op_count), 32'd0);
      bus.out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
